// File: rtl/multichannel_capture_buffer_if.sv
// Readout stream of the capture buffer: one sample per transfer, rd_last marks the window end.
// Transfers complete on rd_valid & rd_ready; the master holds rd_data/rd_last while stalled.
interface multichannel_capture_buffer_if #(
    parameter int NUM_CHANNELS = 7
);
    logic [NUM_CHANNELS-1:0] rd_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic                    rd_last;

    modport master (
        output rd_data,
        output rd_valid,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/multichannel_capture_buffer.sv
// Multi-channel sampler: mask/value trigger with pre-trigger window, circular buffer, oldest-first readout.
// Latency: first readout sample is valid the cycle after the last post-trigger sample is written.
// Backpressure: rd_ready low stalls readout with rd_data/rd_last held; 1 sample/cycle when ready stays high.
module multichannel_capture_buffer #(
    parameter int NUM_CHANNELS = 7,
    parameter int DEPTH        = 80,
    parameter int PRE_TRIG     = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arm,
    input  logic                          abort,
    input  logic [NUM_CHANNELS-1:0]       din,
    input  logic [NUM_CHANNELS-1:0]       trig_mask,
    input  logic [NUM_CHANNELS-1:0]       trig_value,
    input  logic [7:0]                    sample_div,
    multichannel_capture_buffer_if.master rd,
    output logic                          busy,
    output logic                          triggered
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        READOUT
    } state_t;

    state_t state, state_nxt;

    logic [NUM_CHANNELS-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr_inc;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           rd_cnt;
    logic [7:0]              div_latched;
    logic [7:0]              divider;
    logic [NUM_CHANNELS-1:0] rd_data_q;
    logic                    rd_valid_q;
    logic                    rd_last_q;
    logic                    triggered_q;

    logic capturing;
    logic strobe;
    logic trig_hit;
    logic xfer;
    logic arm_accept;
    logic enter_readout;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign capturing  = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    assign strobe     = capturing && (divider == 8'd0);
    assign trig_hit   = (((din ^ trig_value) & trig_mask) == '0);
    assign xfer       = rd_valid_q && rd.rd_ready;
    assign wr_ptr_inc = ptr_inc(wr_ptr);

    assign rd.rd_data  = rd_data_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_last  = rd_last_q;
    assign busy        = (state != IDLE);
    assign triggered   = triggered_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        arm_accept    = 1'b0;
        enter_readout = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    arm_accept = 1'b1;
                    state_nxt  = (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
                end
            end
            PRE: begin
                if (strobe && (cnt == CW'(PRE_TRIG - 1))) begin
                    state_nxt = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (strobe && trig_hit) begin
                    state_nxt = (POST_N == 0) ? READOUT : POST;
                end
            end
            POST: begin
                if (strobe && (cnt == CW'(POST_N - 1))) begin
                    state_nxt = READOUT;
                end
            end
            READOUT: begin
                if (xfer && rd_last_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt  = IDLE;
            arm_accept = 1'b0;
        end
        enter_readout = (state_nxt == READOUT) && (state != READOUT);
    end

    // Sample storage has no reset; only valid, fully-written windows are ever read out.
    always_ff @(posedge clk) begin
        if (strobe) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            rd_cnt      <= '0;
            div_latched <= '0;
            divider     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            triggered_q <= 1'b0;
        end else if (abort) begin
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            if (arm_accept) begin
                div_latched <= sample_div;
                divider     <= '0;
                wr_ptr      <= '0;
                cnt         <= '0;
                rd_cnt      <= '0;
            end

            if (capturing) begin
                divider <= (divider == div_latched) ? 8'd0 : divider + 8'd1;
            end

            if (strobe) begin
                wr_ptr <= wr_ptr_inc;
                case (state)
                    PRE, POST: cnt <= (state_nxt != state) ? '0 : cnt + CW'(1);
                    default:   cnt <= '0;
                endcase
                if ((state == WAIT_TRIG) && trig_hit) begin
                    triggered_q <= 1'b1;
                end
            end

            // The slot after the final write is the oldest sample; prefetch it so readout starts full-rate.
            if (enter_readout) begin
                rd_data_q  <= mem[wr_ptr_inc];
                rd_ptr     <= ptr_inc(wr_ptr_inc);
                rd_cnt     <= CW'(1);
                rd_valid_q <= 1'b1;
                rd_last_q  <= 1'b0;
            end else if ((state == READOUT) && xfer) begin
                if (rd_last_q) begin
                    rd_valid_q  <= 1'b0;
                    rd_last_q   <= 1'b0;
                    triggered_q <= 1'b0;
                end else begin
                    rd_data_q <= mem[rd_ptr];
                    rd_ptr    <= ptr_inc(rd_ptr);
                    rd_cnt    <= rd_cnt + CW'(1);
                    rd_last_q <= (rd_cnt == CW'(DEPTH - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_multichannel_capture_buffer.sv
// Directed bench for multichannel_capture_buffer: three builds (PRE_TRIG 3, 0, 7) with DEPTH 8, 4 channels.
module tb_multichannel_capture_buffer;

    localparam int NC = 4;
    typedef logic [NC-1:0] stream_t [8];

    logic          clk = 1'b0;
    logic          reset;
    logic          abort;
    logic [2:0]    arm;
    logic [2:0]    rdy;
    logic [NC-1:0] din;
    logic [NC-1:0] trig_mask;
    logic [NC-1:0] trig_value;
    logic [7:0]    sample_div;
    wire  [2:0]    busy;
    wire  [2:0]    trig;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multichannel_capture_buffer_if #(.NUM_CHANNELS(NC)) if0 ();
    multichannel_capture_buffer_if #(.NUM_CHANNELS(NC)) if1 ();
    multichannel_capture_buffer_if #(.NUM_CHANNELS(NC)) if2 ();

    assign if0.rd_ready = rdy[0];
    assign if1.rd_ready = rdy[1];
    assign if2.rd_ready = rdy[2];

    wire [2:0]      vld     = {if2.rd_valid, if1.rd_valid, if0.rd_valid};
    wire [2:0]      lst     = {if2.rd_last, if1.rd_last, if0.rd_last};
    wire [3*NC-1:0] dat_all = {if2.rd_data, if1.rd_data, if0.rd_data};

    multichannel_capture_buffer #(.NUM_CHANNELS(NC), .DEPTH(8), .PRE_TRIG(3)) dut0 (
        .clk(clk), .reset(reset), .arm(arm[0]), .abort(abort), .din(din),
        .trig_mask(trig_mask), .trig_value(trig_value), .sample_div(sample_div),
        .rd(if0.master), .busy(busy[0]), .triggered(trig[0])
    );

    multichannel_capture_buffer #(.NUM_CHANNELS(NC), .DEPTH(8), .PRE_TRIG(0)) dut1 (
        .clk(clk), .reset(reset), .arm(arm[1]), .abort(abort), .din(din),
        .trig_mask(trig_mask), .trig_value(trig_value), .sample_div(sample_div),
        .rd(if1.master), .busy(busy[1]), .triggered(trig[1])
    );

    multichannel_capture_buffer #(.NUM_CHANNELS(NC), .DEPTH(8), .PRE_TRIG(7)) dut2 (
        .clk(clk), .reset(reset), .arm(arm[2]), .abort(abort), .din(din),
        .trig_mask(trig_mask), .trig_value(trig_value), .sample_div(sample_div),
        .rd(if2.master), .busy(busy[2]), .triggered(trig[2])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arms one build and ramps din (0,1,2,... from the first strobe) until its readout starts.
    task automatic capture(input int sel, input logic [7:0] div, input logic [NC-1:0] mask,
                           input logic [NC-1:0] value, input string tag);
        int k;
        @(negedge clk);
        sample_div = div;
        trig_mask  = mask;
        trig_value = value;
        din        = '1;
        arm[sel]   = 1'b1;
        @(negedge clk);
        arm[sel]   = 1'b0;
        sample_div = 8'd0;
        k = 0;
        while (!vld[sel] && k < 200) begin
            din      = k[NC-1:0];
            arm[sel] = (k == 5);
            k++;
            @(negedge clk);
        end
        arm[sel] = 1'b0;
        check_val({tag, " start"}, 32'(vld[sel]), 32'd1);
    endtask

    task automatic read_stream(input int sel, input bit stall, input stream_t exp,
                               input int ntake, input string tag);
        int            n    = 0;
        int            cyc  = 0;
        bit            pend = 1'b0;
        logic [NC-1:0] held = '0;
        logic [NC-1:0] d;
        logic          r;
        check_val({tag, " trig"}, 32'(trig[sel]), 32'd1);
        check_val({tag, " busy"}, 32'(busy[sel]), 32'd1);
        while (n < ntake && cyc < 100) begin
            r        = !stall || (cyc % 3 == 0);
            rdy[sel] = r;
            d        = dat_all[sel*NC +: NC];
            if (vld[sel]) begin
                if (pend) check_val({tag, " hold"}, 32'(d), 32'(held));
                if (r) begin
                    check_val($sformatf("%s d%0d", tag, n), 32'(d), 32'(exp[n]));
                    check_val($sformatf("%s last%0d", tag, n), 32'(lst[sel]), 32'(n == 7));
                    n++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    held = d;
                end
            end
            cyc++;
            @(negedge clk);
        end
        rdy[sel] = 1'b0;
        check_val({tag, " count"}, 32'(n), 32'(ntake));
        if (ntake == 8) begin
            check_val({tag, " end vld"}, 32'(vld[sel]), 32'd0);
            check_val({tag, " end busy"}, 32'(busy[sel]), 32'd0);
            check_val({tag, " end trig"}, 32'(trig[sel]), 32'd0);
            repeat (3) @(negedge clk);
            check_val({tag, " no extra"}, 32'(vld[sel]), 32'd0);
        end
    endtask

    initial begin
        stream_t e1, e2, e3, e6, e7;
        int      k;
        bit      seen;

        e1 = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        e2 = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        e3 = '{4'h6, 4'h9, 4'hC, 4'hF, 4'h2, 4'h5, 4'h8, 4'hB};
        e6 = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        e7 = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};

        reset = 1'b1; abort = 1'b0; arm = '0; rdy = '0;
        din = '0; trig_mask = '0; trig_value = '0; sample_div = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst vld", 32'(vld[0]), 32'd0);
        check_val("rst last", 32'(lst[0]), 32'd0);
        check_val("rst busy", 32'(busy[0]), 32'd0);
        check_val("rst trig", 32'(trig[0]), 32'd0);
        check_val("rst data", 32'(dat_all[NC-1:0]), 32'd0);

        capture(0, 8'd0, 4'hF, 4'hA, "t1");
        read_stream(0, 1'b0, e1, 8, "t1");

        capture(0, 8'd0, 4'h0, 4'hA, "t2");
        read_stream(0, 1'b0, e2, 8, "t2");

        capture(0, 8'd2, 4'hF, 4'hF, "t3");
        read_stream(0, 1'b0, e3, 8, "t3");

        capture(0, 8'd0, 4'hF, 4'hA, "t4");
        read_stream(0, 1'b1, e1, 8, "t4");

        // Abort while collecting post-trigger samples, with a simultaneous arm.
        @(negedge clk);
        sample_div = 8'd0; trig_mask = 4'hF; trig_value = 4'hA; din = '1;
        arm[0] = 1'b1;
        @(negedge clk);
        arm[0] = 1'b0;
        k = 0;
        while (!trig[0] && k < 100) begin
            din = k[NC-1:0];
            k++;
            @(negedge clk);
        end
        check_val("t5 trig seen", 32'(trig[0]), 32'd1);
        abort  = 1'b1;
        arm[0] = 1'b1;
        din    = k[NC-1:0];
        @(negedge clk);
        abort  = 1'b0;
        arm[0] = 1'b0;
        check_val("t5 abort busy", 32'(busy[0]), 32'd0);
        check_val("t5 abort trig", 32'(trig[0]), 32'd0);
        seen = 1'b0;
        repeat (15) begin
            if (vld[0]) seen = 1'b1;
            @(negedge clk);
        end
        check_val("t5 no stream", 32'(seen), 32'd0);
        capture(0, 8'd0, 4'h0, 4'hA, "t5b");
        read_stream(0, 1'b0, e2, 8, "t5b");

        capture(1, 8'd0, 4'hF, 4'hA, "t6");
        read_stream(1, 1'b0, e6, 8, "t6");

        capture(2, 8'd0, 4'hF, 4'hA, "t7");
        read_stream(2, 1'b0, e7, 8, "t7");

        capture(0, 8'd0, 4'h0, 4'hA, "t8");
        read_stream(0, 1'b0, e2, 2, "t8");
        reset = 1'b1;
        @(negedge clk);
        check_val("t8 rst vld", 32'(vld[0]), 32'd0);
        check_val("t8 rst busy", 32'(busy[0]), 32'd0);
        check_val("t8 rst trig", 32'(trig[0]), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("t8 idle vld", 32'(vld[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
